// File: rtl/pen_ctrl_pkg.sv
// Shared types and constants for the pen-lift controller.
//   pen_state_t : sequencer state encoding
//   PEN_UP/DOWN : pen position encoding used on req_pen, pen_status, pen_pos
package pen_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MOVE  = 3'd1,
    DONE  = 3'd2,
    ERROR = 3'd3
  } pen_state_t;

  localparam logic PEN_UP   = 1'b0;
  localparam logic PEN_DOWN = 1'b1;

endpackage

// File: rtl/pen_debounce.sv
// Two-flop synchroniser followed by a stability filter.
// dout only changes after CYCLES consecutive synchronised samples that all
// differ from the current dout; any agreeing sample restarts the count.
// Ports:
//   gclk, grst_n : clock, async active-low reset (dout resets to 0)
//   din          : raw asynchronous input
//   dout         : registered, debounced level
module pen_debounce #(
  parameter int CYCLES = 50_000
) (
  input  logic gclk,
  input  logic grst_n,
  input  logic din,
  output logic dout
);

  localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  logic          s1, s2;
  logic [CW-1:0] cnt;

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      cnt  <= '0;
      dout <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      if (s2 != dout) begin
        // cnt holds the number of differing samples already seen, so the
        // CYCLES-th one is the sample arriving while cnt == CYCLES-1
        if (cnt == LAST) begin
          dout <= s2;
          cnt  <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/pen_lift_controller.sv
// Command-side sequencer for the pen-lift DC motor driver.
// Takes pen up/down commands on a valid/ready handshake, drives the motor
// driver, confirms the move from debounced pen_status and reports done,
// timeout and driver fault.
// Build option: PEN_RETRY_EN -- first timeout of a command retries once
// (1-cycle enable gap, counter restart) instead of erroring.
// Ports:
//   clk_50, reset_n       : clock, async active-low reset
//   req_valid/req_ready   : command handshake; req_pen = target, duty_cfg latched on accept
//   pen_status, fault_n   : asynchronous driver feedback
//   err_clear             : leave ERROR and clear sticky flags
//   motor_enable/duty/set_pen : driver controls
//   pen_pos               : debounced confirmed position
//   busy, done_pulse, timeout_err, fault_err : status to motion core
module pen_lift_controller
  import pen_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50_000,
  parameter int TIMEOUT_CYCLES  = 25_000_000,
  parameter int TO_W            = 25
) (
  input  logic        clk_50,
  input  logic        reset_n,
  input  logic        req_valid,
  input  logic        req_pen,
  input  logic [15:0] duty_cfg,
  output logic        req_ready,
  input  logic        pen_status,
  input  logic        fault_n,
  input  logic        err_clear,
  output logic        motor_enable,
  output logic [15:0] motor_duty,
  output logic        motor_set_pen,
  output logic        pen_pos,
  output logic        busy,
  output logic        done_pulse,
  output logic        timeout_err,
  output logic        fault_err
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  pen_state_t      state, state_d;
  logic [TO_W-1:0] cnt, cnt_d;
  logic            fault_s1, fault_s2;
  logic            init_q;
  logic            target;
  logic            pos_db;
  logic            accept, to_set, flt_set, err_clr;
`ifdef PEN_RETRY_EN
  logic            retried, retried_d;
  logic            gap, gap_d;
`endif

  pen_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_pen_db (
    .gclk   (clk_50),
    .grst_n (reset_n),
    .din    (pen_status),
    .dout   (pos_db)
  );

  // Ready is held off for the first cycle after reset release, and while a
  // synchronised fault is pending so a command is never taken in the same
  // cycle the sequencer is forced into ERROR.
  assign req_ready     = (state == IDLE) & init_q & fault_s2;
  assign accept        = req_valid & req_ready;
  assign busy          = (state == MOVE);
  assign done_pulse    = (state == DONE);
  assign motor_set_pen = target;
  assign pen_pos       = pos_db;
`ifdef PEN_RETRY_EN
  assign motor_enable  = (state == MOVE) & ~gap;
`else
  assign motor_enable  = (state == MOVE);
`endif

  always_comb begin
    state_d = state;
    cnt_d   = '0;
    to_set  = 1'b0;
    flt_set = 1'b0;
    err_clr = 1'b0;
`ifdef PEN_RETRY_EN
    retried_d = retried;
    gap_d     = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (!fault_s2) begin
          state_d = ERROR;
          flt_set = 1'b1;
        end else if (accept) begin
          state_d = (req_pen == pos_db) ? DONE : MOVE;
        end
      end
      MOVE: begin
        // priority: fault, then position match, then timeout
        if (!fault_s2) begin
          state_d = ERROR;
          flt_set = 1'b1;
        end else if (pos_db == target) begin
          state_d = DONE;
`ifdef PEN_RETRY_EN
        end else if (!gap && cnt == TO_LAST) begin
          if (!retried) begin
            retried_d = 1'b1;
            gap_d     = 1'b1;
          end else begin
            state_d = ERROR;
            to_set  = 1'b1;
          end
        end else begin
          // counter stays at 0 through the gap so the retry gets a full window
          cnt_d = gap ? '0 : cnt + TO_W'(1);
        end
`else
        end else if (cnt == TO_LAST) begin
          state_d = ERROR;
          to_set  = 1'b1;
        end else begin
          cnt_d = cnt + TO_W'(1);
        end
`endif
      end
      DONE: begin
        if (!fault_s2) begin
          state_d = ERROR;
          flt_set = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      ERROR: begin
        if (err_clear) begin
          state_d = IDLE;
          err_clr = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef PEN_RETRY_EN
    if (state != MOVE) retried_d = 1'b0;
`endif
  end

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      fault_s1    <= 1'b1;
      fault_s2    <= 1'b1;
      init_q      <= 1'b0;
      target      <= PEN_UP;
      motor_duty  <= '0;
      timeout_err <= 1'b0;
      fault_err   <= 1'b0;
`ifdef PEN_RETRY_EN
      retried     <= 1'b0;
      gap         <= 1'b0;
`endif
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      fault_s1 <= fault_n;
      fault_s2 <= fault_s1;
      init_q   <= 1'b1;
      if (accept) begin
        target     <= req_pen;
        motor_duty <= duty_cfg;
      end
      timeout_err <= err_clr ? 1'b0 : (timeout_err | to_set);
      fault_err   <= err_clr ? 1'b0 : (fault_err | flt_set);
`ifdef PEN_RETRY_EN
      retried <= retried_d;
      gap     <= gap_d;
`endif
    end
  end

endmodule

// File: tb/tb_pen_lift_controller.sv
`timescale 1ns/1ps
module tb_pen_lift_controller;

  localparam int DB = 4;
  localparam int TO = 100;

  logic        clk_50 = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_pen = 1'b0;
  logic [15:0] duty_cfg = '0;
  logic        pen_status = 1'b0;
  logic        fault_n = 1'b1;
  logic        err_clear = 1'b0;
  logic        req_ready, motor_enable, motor_set_pen, pen_pos;
  logic        busy, done_pulse, timeout_err, fault_err;
  logic [15:0] motor_duty;

  always #5 clk_50 = ~clk_50;

  pen_lift_controller #(
    .DEBOUNCE_CYCLES (DB),
    .TIMEOUT_CYCLES  (TO),
    .TO_W            (8)
  ) dut (
    .clk_50        (clk_50),
    .reset_n       (reset_n),
    .req_valid     (req_valid),
    .req_pen       (req_pen),
    .duty_cfg      (duty_cfg),
    .req_ready     (req_ready),
    .pen_status    (pen_status),
    .fault_n       (fault_n),
    .err_clear     (err_clear),
    .motor_enable  (motor_enable),
    .motor_duty    (motor_duty),
    .motor_set_pen (motor_set_pen),
    .pen_pos       (pen_pos),
    .busy          (busy),
    .done_pulse    (done_pulse),
    .timeout_err   (timeout_err),
    .fault_err     (fault_err)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s got=%0h exp=%0h edge=%0d", tag, got, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // Sequencer modes; the debouncer is modelled as "the last DB synchronised
  // samples all disagree with the current position", synchronisation as a
  // two-edge delay over a sample history.
  localparam int M_IDLE = 0, M_MOVE = 1, M_DONE = 2, M_ERR = 3;
  int          m_mode, m_start;
  bit          m_started, m_tgt, m_pos, m_to, m_fe, m_retried, m_gap;
  logic [15:0] m_duty;
  bit          ps_q[$];
  bit          fn_q[$];

  function automatic void model_reset();
    m_mode = M_IDLE; m_start = 0; m_started = 0; m_tgt = 0; m_pos = 0;
    m_to = 0; m_fe = 0; m_retried = 0; m_gap = 0; m_duty = '0;
    ps_q.delete(); fn_q.delete();
    for (int i = 0; i < DB + 2; i++) begin
      ps_q.push_back(1'b0);
      fn_q.push_back(1'b1);
    end
  endfunction

  // synchronised fault level currently seen by the sequencer
  function automatic bit sync_fault_ok();
    return fn_q[fn_q.size() - 2];
  endfunction

  function automatic bit exp_ready();
    return (m_mode == M_IDLE) && m_started && sync_fault_ok();
  endfunction

  function automatic void model_edge();
    bit fs, acc, was_gap, flip, v;
    int n;
    fs      = sync_fault_ok();
    acc     = req_valid && exp_ready();
    was_gap = m_gap;
    m_gap   = 0;
    case (m_mode)
      M_IDLE: begin
        if (!fs) begin m_mode = M_ERR; m_fe = 1; end
        else if (acc) begin
          m_tgt = req_pen; m_duty = duty_cfg;
          if (req_pen == m_pos) m_mode = M_DONE;
          else begin m_mode = M_MOVE; m_start = cyc; end
        end
      end
      M_MOVE: begin
        if (!fs) begin m_mode = M_ERR; m_fe = 1; end
        else if (m_pos == m_tgt) m_mode = M_DONE;
        else if (!was_gap && (cyc - m_start) == TO) begin
`ifdef PEN_RETRY_EN
          if (!m_retried) begin m_retried = 1; m_gap = 1; end
          else begin m_mode = M_ERR; m_to = 1; end
`else
          m_mode = M_ERR; m_to = 1;
`endif
        end
        else if (was_gap) m_start = cyc;
      end
      M_DONE: begin
        if (!fs) begin m_mode = M_ERR; m_fe = 1; end
        else m_mode = M_IDLE;
      end
      default: begin
        if (err_clear) begin m_mode = M_IDLE; m_to = 0; m_fe = 0; end
      end
    endcase
    if (m_mode != M_MOVE) m_retried = 0;
    n = ps_q.size();
    v = ps_q[n - 2];
    flip = (v != m_pos);
    for (int i = 0; i < DB; i++) if (ps_q[n - 2 - i] != v) flip = 0;
    if (flip) m_pos = v;
    ps_q.push_back(pen_status); void'(ps_q.pop_front());
    fn_q.push_back(fault_n);    void'(fn_q.pop_front());
    m_started = 1;
    cyc++;
  endfunction

  task automatic compare_all();
    chk("req_ready",     32'(req_ready),     32'(exp_ready()));
    chk("motor_enable",  32'(motor_enable),  32'(m_mode == M_MOVE && !m_gap));
    chk("busy",          32'(busy),          32'(m_mode == M_MOVE));
    chk("done_pulse",    32'(done_pulse),    32'(m_mode == M_DONE));
    chk("motor_set_pen", 32'(motor_set_pen), 32'(m_tgt));
    chk("motor_duty",    32'(motor_duty),    32'(m_duty));
    chk("pen_pos",       32'(pen_pos),       32'(m_pos));
    chk("timeout_err",   32'(timeout_err),   32'(m_to));
    chk("fault_err",     32'(fault_err),     32'(m_fe));
  endtask

  // inputs change only at negedge, between ticks
  task automatic tick();
    @(posedge clk_50);
    if (reset_n) model_edge();
    @(negedge clk_50);
    compare_all();
  endtask

  task automatic accept_cmd(input logic pen, input logic [15:0] duty);
    req_valid = 1'b1; req_pen = pen; duty_cfg = duty;
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    #(5_000_000);
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_done, n_en, t_to, gaps;
    bit moved, stuck;
    model_reset();

    // reset state
    repeat (3) tick();
    reset_n = 1'b1;
    chk("ready_before_first_edge", 32'(req_ready), 32'(0));
    tick();
    chk("ready_after_release", 32'(req_ready), 32'(1));

    // 1: pen down move
    accept_cmd(1'b1, 16'h0040);
    chk("t1_enable", 32'(motor_enable), 32'(1));
    chk("t1_set_pen", 32'(motor_set_pen), 32'(1));
    chk("t1_duty", 32'(motor_duty), 32'h0040);
    repeat (19) tick();
    pen_status = 1'b1;
    n_done = -1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (done_pulse && n_done < 0) n_done = i;
    end
    chk("t1_done_latency", 32'(n_done), 32'(7));
    chk("t1_pen_pos", 32'(pen_pos), 32'(1));

    // 2: already down
    n_en = 0;
    accept_cmd(1'b1, 16'h1234);
    chk("t2_done_next", 32'(done_pulse), 32'(1));
    if (motor_enable) n_en++;
    for (int i = 0; i < 3; i++) begin tick(); if (motor_enable) n_en++; end
    chk("t2_no_enable", 32'(n_en), 32'(0));

    // 3/6: stuck pen -> timeout (with retry when enabled)
    accept_cmd(1'b0, 16'h0080);
    t_to = -1; gaps = 0;
    for (int i = 1; i <= 230; i++) begin
      tick();
      if (timeout_err && t_to < 0) t_to = i;
      if (busy && !motor_enable) gaps++;
    end
`ifdef PEN_RETRY_EN
    chk("t6_timeout_at", 32'(t_to), 32'(201));
    chk("t6_enable_gaps", 32'(gaps), 32'(1));
`else
    chk("t3_timeout_at", 32'(t_to), 32'(100));
    chk("t3_enable_gaps", 32'(gaps), 32'(0));
`endif
    chk("t3_err_enable", 32'(motor_enable), 32'(0));
    chk("t3_err_ready", 32'(req_ready), 32'(0));
    req_valid = 1'b1; req_pen = 1'b1; duty_cfg = 16'hBEEF; err_clear = 1'b1;
    tick();
    req_valid = 1'b0; err_clear = 1'b0;
    chk("t3_to_cleared", 32'(timeout_err), 32'(0));
    chk("t3_no_accept_in_error", 32'(motor_duty), 32'h0080);
    chk("t3_ready_idle", 32'(req_ready), 32'(1));

    // 4: bouncing feedback, exactly one done
    accept_cmd(1'b0, 16'h0011);
    n_done = 0; moved = 0;
    for (int i = 0; i < 30; i++) begin
      pen_status = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
      tick();
      if (pen_pos !== 1'b1) moved = 1;
      if (done_pulse) n_done++;
    end
    pen_status = 1'b0;
    for (int i = 0; i < 20; i++) begin tick(); if (done_pulse) n_done++; end
    chk("t4_pos_held", 32'(moved), 32'(0));
    chk("t4_one_done", 32'(n_done), 32'(1));
    chk("t4_pen_pos", 32'(pen_pos), 32'(0));

    // 5: fault at MOVE cycle 10
    accept_cmd(1'b1, 16'h0022);
    repeat (9) tick();
    fault_n = 1'b0;
    tick(); tick();
    chk("t5_fault_not_yet", 32'(fault_err), 32'(0));
    tick();
    chk("t5_fault_err", 32'(fault_err), 32'(1));
    chk("t5_fault_enable", 32'(motor_enable), 32'(0));
    err_clear = 1'b1; tick(); err_clear = 1'b0;
    chk("t5_clear_with_fault", 32'(fault_err), 32'(0));
    tick();
    chk("t5_fault_reenter", 32'(fault_err), 32'(1));
    fault_n = 1'b1; tick(); tick();
    err_clear = 1'b1; tick(); err_clear = 1'b0; tick();
    chk("t5_recovered_ready", 32'(req_ready), 32'(1));

    // 5b: fault and position match reach the sequencer on the same edge
    accept_cmd(1'b1, 16'h0033);
    repeat (3) tick();
    pen_status = 1'b1;
    repeat (4) tick();
    fault_n = 1'b0;
    n_done = 0;
    for (int i = 0; i < 6; i++) begin tick(); if (done_pulse) n_done++; end
    chk("t5b_no_done", 32'(n_done), 32'(0));
    chk("t5b_fault_err", 32'(fault_err), 32'(1));
    fault_n = 1'b1; tick(); tick();
    err_clear = 1'b1; tick(); err_clear = 1'b0; tick();

    // 7: async reset mid-MOVE
    accept_cmd(1'b0, 16'h0044);
    repeat (5) tick();
    reset_n = 1'b0;
    #1;
    chk("t7_async_enable", 32'(motor_enable), 32'(0));
    chk("t7_async_busy", 32'(busy), 32'(0));
    model_reset();
    tick(); tick();
    reset_n = 1'b1;
    tick();

    // random traffic with a crude driver emulation
    stuck = 0;
    for (int i = 0; i < 3000; i++) begin
      req_valid = ($urandom_range(0, 3) == 0);
      req_pen   = 1'($urandom_range(0, 1));
      duty_cfg  = 16'($urandom);
      err_clear = (m_mode == M_ERR) && ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 499) == 0) stuck = ~stuck;
      if (m_mode == M_MOVE && !stuck && $urandom_range(0, 9) == 0) pen_status = m_tgt;
      if ($urandom_range(0, 29) == 0) pen_status = ~pen_status;
      if (fault_n && $urandom_range(0, 299) == 0) fault_n = 1'b0;
      else if (!fault_n && $urandom_range(0, 3) == 0) fault_n = 1'b1;
      if ($urandom_range(0, 1499) == 0) begin
        reset_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        tick();
        reset_n = 1'b1;
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
